// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word fetches under a credit limit,
// buffers returned words with their PCs and hands them to decode; redirect flushes.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = CW + 1;
   localparam logic [SW-1:0] L_DEPTH = SW'(DEPTH);

   logic [31:0]   r_fetch_pc;
   logic [CW-1:0] r_inflight;
   logic [CW-1:0] r_drop_cnt;
   logic [CW-1:0] r_count;
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW-1:0] r_pq_wptr;
   logic [AW-1:0] r_pq_rptr;
   logic [31:0]   r_pcq   [DEPTH];
   logic [31:0]   r_fpc   [DEPTH];
   logic [31:0]   r_fdata [DEPTH];

   logic          w_req_valid;
   logic          w_req_fire;
   logic          w_rsp_drop;
   logic          w_enq;
   logic          w_deq;
   logic [CW-1:0] w_inflight_nxt;
   logic [CW-1:0] w_drop_nxt;
   logic [CW-1:0] w_count_nxt;

   // Credit check, handshake qualification and next-count arithmetic.
   always_comb begin
      w_req_valid    = rst_n && !redirect_valid &&
                       (({1'b0, r_inflight} + {1'b0, r_count}) < L_DEPTH);
      w_req_fire     = w_req_valid && imem_req_ready;
      w_rsp_drop     = (r_drop_cnt != {CW{1'b0}});
      w_enq          = imem_rsp_valid && !w_rsp_drop && !redirect_valid;
      w_deq          = (r_count != {CW{1'b0}}) && instr_ready && !redirect_valid;
      w_inflight_nxt = r_inflight + CW'(w_req_fire) - CW'(imem_rsp_valid);
      w_drop_nxt     = r_drop_cnt;
      w_count_nxt    = r_count;
      if (redirect_valid) begin
         // Every outstanding fetch (including those already doomed) is now stale.
         w_drop_nxt  = r_inflight - CW'(imem_rsp_valid);
         w_count_nxt = {CW{1'b0}};
      end else begin
         if (imem_rsp_valid && w_rsp_drop) begin
            w_drop_nxt = r_drop_cnt - CW'(1);
         end else begin
            w_drop_nxt = r_drop_cnt;
         end
         w_count_nxt = r_count + CW'(w_enq) - CW'(w_deq);
      end
   end

   // PC, counters and pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= {RESET_PC[31:2], 2'b00};
         r_inflight <= {CW{1'b0}};
         r_drop_cnt <= {CW{1'b0}};
         r_count    <= {CW{1'b0}};
         r_wptr     <= {AW{1'b0}};
         r_rptr     <= {AW{1'b0}};
         r_pq_wptr  <= {AW{1'b0}};
         r_pq_rptr  <= {AW{1'b0}};
      end else begin
         r_inflight <= w_inflight_nxt;
         r_drop_cnt <= w_drop_nxt;
         r_count    <= w_count_nxt;
         r_pq_wptr  <= r_pq_wptr + AW'(w_req_fire);
         r_pq_rptr  <= r_pq_rptr + AW'(imem_rsp_valid);
         if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_wptr     <= {AW{1'b0}};
            r_rptr     <= {AW{1'b0}};
         end else begin
            if (w_req_fire) begin
               r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_wptr <= r_wptr + AW'(w_enq);
            r_rptr <= r_rptr + AW'(w_deq);
         end
      end
   end

   // Storage: PCs of in-flight fetches, and the {pc, data} instruction buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_pcq[i]   <= 32'h0000_0000;
            r_fpc[i]   <= 32'h0000_0000;
            r_fdata[i] <= 32'h0000_0000;
         end
      end else begin
         if (w_req_fire) begin
            r_pcq[r_pq_wptr] <= r_fetch_pc;
         end
         if (w_enq) begin
            r_fpc[r_wptr]   <= r_pcq[r_pq_rptr];
            r_fdata[r_wptr] <= imem_rsp_data;
         end
      end
   end

   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = r_fetch_pc;
   assign instr_valid    = (r_count != {CW{1'b0}});
   assign instr          = r_fdata[r_rptr];
   assign instr_pc       = r_fpc[r_rptr];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed cycle table, then randomized traffic
// against a queue-based reference model and a variable-latency memory.
module tb_instr_fetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;

   instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
   endfunction

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        qr;
      logic        sv;
      logic [31:0] sd;
      logic        ir;
      logic        e_qv;
      logic [31:0] e_qa;
      logic        e_iv;
      logic [31:0] e_pc;
      logic [31:0] e_in;
   } vec_t;
   vec_t tbl[20];

   typedef struct { logic [31:0] pc; bit stale; } of_t;
   typedef struct { logic [31:0] pc; logic [31:0] data; } fe_t;
   typedef struct { logic [31:0] addr; int due; } pd_t;
   of_t         m_out[$];
   fe_t         m_fifo[$];
   pd_t         mem_q[$];
   logic [31:0] m_pc;
   of_t         e;

   logic        exp_qv, fire_s, rsp_s;
   logic [31:0] addr_s, rdata_s;
   int          last_due, due;

   initial begin
      // rv rpc qr sv sd ir | qv qaddr iv pc instr
      tbl[0]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 32'h0};
      tbl[1]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h1111_0000, 1'b1, 1'b1, 32'h0000_0104, 1'b0, 32'h0, 32'h0};
      tbl[2]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h1111_0004, 1'b1, 1'b0, 32'h0000_0108, 1'b1, 32'h0000_0100, 32'h1111_0000};
      tbl[3]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0104, 32'h1111_0004};
      tbl[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h1111_0008, 1'b0, 1'b0, 32'h0000_010C, 1'b1, 32'h0000_0104, 32'h1111_0004};
      tbl[5]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_010C, 1'b1, 32'h0000_0104, 32'h1111_0004};
      tbl[6]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_010C, 1'b1, 32'h0000_0104, 32'h1111_0004};
      tbl[7]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_010C, 1'b1, 32'h0000_0108, 32'h1111_0008};
      tbl[8]  = '{1'b1, 32'h0000_2002, 1'b1, 1'b1, 32'h1111_000C, 1'b1, 1'b0, 32'h0000_0110, 1'b0, 32'h0, 32'h0};
      tbl[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_2000, 1'b0, 32'h0, 32'h0};
      tbl[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_2004, 1'b0, 32'h0, 32'h0};
      tbl[11] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hDEAD_0001, 1'b1, 1'b0, 32'h0000_2008, 1'b0, 32'h0, 32'h0};
      tbl[12] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0};
      tbl[13] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_0002, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0, 32'h0};
      tbl[14] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h7777_FFFC, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0};
      tbl[15] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC, 32'h7777_FFFC};
      tbl[16] = '{1'b1, 32'h0000_0300, 1'b1, 1'b1, 32'h5555_0000, 1'b1, 1'b0, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC, 32'h7777_FFFC};
      tbl[17] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'h0, 32'h0};
      tbl[18] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h3000_0300, 1'b1, 1'b1, 32'h0000_0304, 1'b0, 32'h0, 32'h0};
      tbl[19] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0304, 1'b1, 32'h0000_0300, 32'h3000_0300};

      repeat (2) @(negedge clk);
      chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      chk("rst_req_addr", imem_req_addr, RESET_PC);
      chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);

      // Directed table: row 0 is the first cycle after reset release.
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i != 0) @(negedge clk);
         redirect_valid = tbl[i].rv;
         redirect_pc    = tbl[i].rpc;
         imem_req_ready = tbl[i].qr;
         imem_rsp_valid = tbl[i].sv;
         imem_rsp_data  = tbl[i].sd;
         instr_ready    = tbl[i].ir;
         #1;
         chk($sformatf("tbl%0d_req_valid", i), {31'h0, imem_req_valid}, {31'h0, tbl[i].e_qv});
         chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].e_qa);
         chk($sformatf("tbl%0d_instr_valid", i), {31'h0, instr_valid}, {31'h0, tbl[i].e_iv});
         if (tbl[i].e_iv) begin
            chk($sformatf("tbl%0d_instr_pc", i), instr_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_in);
         end
      end

      // Randomized phase; DUT is idle with fetch_pc 0x304 after the table.
      m_pc = 32'h0000_0304;
      last_due = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         redirect_valid = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else redirect_pc = $urandom;
         imem_req_ready = ($urandom_range(0, 1) == 1);
         instr_ready    = ($urandom_range(0, 3) != 0);
         if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
         end
         #1;
         exp_qv = !redirect_valid && ((m_out.size() + m_fifo.size()) < DEPTH);
         chk("rnd_req_valid", {31'h0, imem_req_valid}, {31'h0, exp_qv});
         chk("rnd_req_addr", imem_req_addr, m_pc);
         chk("rnd_instr_valid", {31'h0, instr_valid}, {31'h0, (m_fifo.size() != 0)});
         if (m_fifo.size() != 0) begin
            chk("rnd_instr_pc", instr_pc, m_fifo[0].pc);
            chk("rnd_instr", instr, m_fifo[0].data);
            chk("rnd_instr_memword", instr, mem_word(instr_pc));
         end
         fire_s  = imem_req_valid && imem_req_ready;
         addr_s  = imem_req_addr;
         rsp_s   = imem_rsp_valid;
         rdata_s = imem_rsp_data;
         @(posedge clk);
         if (rsp_s) void'(mem_q.pop_front());
         if (fire_s) begin
            due = cyc + int'($urandom_range(1, 4));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr_s, due});
         end
         e = '{32'h0, 1'b1};
         if (rsp_s && m_out.size() > 0) e = m_out.pop_front();
         if (redirect_valid) begin
            foreach (m_out[k]) m_out[k].stale = 1'b1;
            m_fifo.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
         end else begin
            if (instr_ready && m_fifo.size() != 0) void'(m_fifo.pop_front());
            if (rsp_s && !e.stale) m_fifo.push_back('{e.pc, rdata_s});
            if (exp_qv && imem_req_ready) begin
               m_out.push_back('{m_pc, 1'b0});
               m_pc = m_pc + 32'd4;
            end
         end
      end

      // Asynchronous reset in the middle of a cycle clears outputs at once.
      @(negedge clk);
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      chk("mid_rst_req_addr", imem_req_addr, RESET_PC);
      chk("mid_rst_instr_valid", {31'h0, instr_valid}, 32'h0);
      chk("mid_rst_instr", instr, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
